// File: rtl/lfsr_pkg.sv
// Shared definitions for the LFSR step sequencer: FSM encoding, default
// register indices and the next-state function.
package lfsr_pkg;

  localparam int LFSR_W = 8;

  localparam int STATE_REG_DEF = 3;
  localparam int TAP_REG_DEF   = 2;
  localparam int CNT_REG_DEF   = 14;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    WSTATE,
    WCNT,
    FIN
  } lfsr_state_t;

  // Left shift with the parity of the tapped bits fed into the LSB.
  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] state,
                                                  input logic [LFSR_W-1:0] taps);
    return {state[LFSR_W-2:0], ^(state & taps)};
  endfunction

endpackage

// File: rtl/lfsr_step_ctrl.sv
// Runs N LFSR steps through the shared register file, writing back the new
// state and the step count on alternating cycles via the single write port.
module lfsr_step_ctrl
  import lfsr_pkg::*;
#(
  parameter int W         = 8,
  parameter int D         = 4,
  parameter int STATE_REG = STATE_REG_DEF,
  parameter int TAP_REG   = TAP_REG_DEF,
  parameter int CNT_REG   = CNT_REG_DEF
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic         Start,
  input  logic [W-1:0] Steps,
  input  logic [W-1:0] RfDataA,
  input  logic [W-1:0] RfDataB,
  output logic [D-1:0] RfRaddrA,
  output logic [D-1:0] RfRaddrB,
  output logic [D-1:0] RfWaddr,
  output logic         RfWriteEn,
  output logic [W-1:0] RfDataIn,
  output logic         Busy,
  output logic         Done,
  output logic [W-1:0] StateOut
);

  lfsr_state_t  fsm_q;
  logic [W-1:0] state_q;
  logic [W-1:0] taps_q;
  logic [W-1:0] cnt_q;
  logic [W-1:0] steps_q;
  logic [W-1:0] cnt_inc;

  assign RfRaddrA = D'(STATE_REG);
  assign RfRaddrB = D'(TAP_REG);
  assign StateOut = state_q;
  assign cnt_inc  = cnt_q + 1'b1;

  // Port outputs are registered one cycle ahead: each transition loads the
  // values the next state presents to the register file.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      fsm_q     <= IDLE;
      state_q   <= '0;
      taps_q    <= '0;
      cnt_q     <= '0;
      steps_q   <= '0;
      RfWaddr   <= '0;
      RfWriteEn <= 1'b0;
      RfDataIn  <= '0;
      Busy      <= 1'b0;
      Done      <= 1'b0;
    end else begin
      RfWriteEn <= 1'b0;
      RfWaddr   <= '0;
      RfDataIn  <= '0;
      Done      <= 1'b0;
      case (fsm_q)
        IDLE: begin
          if (Start) begin
            steps_q <= Steps;
            fsm_q   <= LOAD;
            Busy    <= 1'b1;
          end
        end
        LOAD: begin
          state_q <= RfDataA;
          taps_q  <= RfDataB;
          cnt_q   <= '0;
          if (steps_q == '0) begin
            fsm_q <= FIN;
            Done  <= 1'b1;
          end else begin
            fsm_q     <= WSTATE;
            RfWriteEn <= 1'b1;
            RfWaddr   <= D'(STATE_REG);
            RfDataIn  <= lfsr_next(RfDataA, RfDataB);
          end
        end
        WSTATE: begin
          state_q   <= lfsr_next(state_q, taps_q);
          fsm_q     <= WCNT;
          RfWriteEn <= 1'b1;
          RfWaddr   <= D'(CNT_REG);
          RfDataIn  <= cnt_inc;
        end
        WCNT: begin
          cnt_q <= cnt_inc;
          if (cnt_inc == steps_q) begin
            fsm_q <= FIN;
            Done  <= 1'b1;
          end else begin
            // state_q already holds the value just written back
            fsm_q     <= WSTATE;
            RfWriteEn <= 1'b1;
            RfWaddr   <= D'(STATE_REG);
            RfDataIn  <= lfsr_next(state_q, taps_q);
          end
        end
        FIN: begin
          fsm_q <= IDLE;
          Busy  <= 1'b0;
        end
        default: begin
          fsm_q <= IDLE;
          Busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/lfsr_step_ctrl.md
# lfsr_step_ctrl

Sequencer that runs N LFSR steps through the shared 8-bit register file. It reads the current LFSR state and tap pattern from their fixed registers, computes each next state, and writes back both the state and a step counter through the file's single write port. It sits beside the CPU datapath. While `Busy` is high, the top level routes the register-file address, write-enable and data ports from this block instead of the CPU.

## Interface
Parameters:
- `W`, 8: data width; matches register-file width.
- `D`, 4: register address width.
- `STATE_REG`, 3: register index holding the LFSR state.
- `TAP_REG`, 2: register index holding the tap pattern.
- `CNT_REG`, 14: register index receiving the step count.

Ports:
- `Clk`  in  1: the design clock.
- `Reset`  in  1: asynchronous, active-low reset.
- `Start`  in  1: request a run; sampled only in IDLE.
- `Steps`  in  W: number of LFSR steps; latched on an accepted `Start`.
- `RfDataA`  in  W: register-file `DataOutA` (combinational read of `RfRaddrA`).
- `RfDataB`  in  W: register-file `DataOutB` (combinational read of `RfRaddrB`).
- `RfRaddrA`  out  D: read address A; constant `STATE_REG`.
- `RfRaddrB`  out  D: read address B; constant `TAP_REG`.
- `RfWaddr`  out  D: write address.
- `RfWriteEn`  out  1: write strobe.
- `RfDataIn`  out  W: write data.
- `Busy`  out  1: block owns the register-file ports.
- `Done`  out  1: one-cycle completion pulse.
- `StateOut`  out  W: current internal LFSR state register.

## Operation
- FSM states: IDLE, LOAD, WSTATE, WCNT, FIN.
- IDLE:
  - `Start`=1 latches `Steps` into `steps_q` and goes to LOAD.
  - Otherwise stays in IDLE.
- LOAD:
  - Latches `state_q`←`RfDataA` and `taps_q`←`RfDataB`; clears `cnt_q`←0.
  - Goes to FIN if `steps_q`=0, else to WSTATE.
- WSTATE:
  - Computes `nxt` = {`state_q`[W-2:0], ^(`state_q` & `taps_q`)}: left shift, feedback parity into the LSB.
  - Drives `RfWriteEn`=1, `RfWaddr`=`STATE_REG`, `RfDataIn`=`nxt`; updates `state_q`←`nxt`.
  - Goes to WCNT.
- WCNT:
  - Drives `RfWriteEn`=1, `RfWaddr`=`CNT_REG`, `RfDataIn`=`cnt_q`+1; updates `cnt_q`←`cnt_q`+1.
  - Goes to FIN if `cnt_q`+1 = `steps_q`, else to WSTATE.
- FIN: `Done`=1; goes to IDLE.
- Outside WSTATE and WCNT: `RfWriteEn`=0, `RfWaddr`=0, `RfDataIn`=0.
- `Busy` = (FSM ≠ IDLE). It covers LOAD through FIN inclusive.
- Arithmetic:
  - `cnt_q` is W bits wide, so `Steps`=255 is the maximum run.
  - No wrap is possible because termination occurs on equality with `steps_q`.
- `Start` while not in IDLE is ignored, including in the FIN cycle. `Steps` changes mid-run have no effect.

## Timing
- Accepted `Start` at edge 0:
  - LOAD occupies cycle 1.
  - The first state write commits at edge 2.
- Each step is exactly 2 cycles: a state write, then a counter write.
- `Done` is high during cycle 2N+2 after the accepting edge; N=0 gives `Done` in cycle 2.
- The next `Start` can be accepted in cycle 2N+3.
- Reset (asserted low, asynchronous):
  - FSM→IDLE; `state_q`, `taps_q`, `cnt_q`, `steps_q` → 0.
  - All outputs read 0, except `RfRaddrA`=`STATE_REG` and `RfRaddrB`=`TAP_REG`.
  - Reset mid-run aborts immediately, with no further writes. Writes already committed remain in the register file.
- Reset deassertion is synchronized externally; the block needs no internal synchronizer.

## Structure
- Package `lfsr_pkg`:
  - FSM enum `lfsr_state_t`.
  - Default register-index constants (`STATE_REG_DEF`=3, `TAP_REG_DEF`=2, `CNT_REG_DEF`=14).
  - Function `lfsr_next(state, taps)` for reuse by the bench model.
- Single module; no sub-module. The next-state logic is the package function.

## Test plan
- State 0x01, taps 0x80, `Steps`=3 → STATE_REG writes 0x02, 0x04, 0x08; CNT_REG writes 1, 2, 3; `Done` in cycle 8; `StateOut`=0x08.
- State 0x80, taps 0x80, `Steps`=1 → STATE_REG writes 0x01; CNT_REG writes 1; `Done` in cycle 4.
- State 0xB8, taps 0xB8, `Steps`=0 → no `RfWriteEn` pulse; `Done` in cycle 2; `Busy` high only in cycles 1–2.
- `Start` pulsed during WSTATE of a 2-step run → ignored: exactly 4 writes, one `Done`. A new `Start` in cycle 7 is accepted.
- `Reset` driven low during the second WCNT of a 3-step run → FSM returns to IDLE at once; `RfWriteEn`, `Busy`, `Done` go to 0; CNT_REG holds 1.
- Back-to-back runs with `Steps`=255 from state 0x01, taps 0xB8 → 510 writes, final `StateOut` matching the `lfsr_next` model; `Done` in cycle 512.
